// File: rtl/instrumented_pkg.sv
// instrumented_pkg: shared FSM encoding and window-counter width for the counter bank
package instrumented_pkg;

    localparam int WINDOW_CNT_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARM,
        ST_COUNT,
        ST_DONE
    } state_e;

endpackage

// File: rtl/ring_edge_counter.sv
// ring_edge_counter: synchronise one ring-oscillator tap, detect rising edges, count with saturation
module ring_edge_counter #(
    parameter int CNT_W       = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             ring_in,
    input  logic             clear,
    input  logic             count_en,
    output logic [CNT_W-1:0] cnt,
    output logic             ovf
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   ovf_q, ovf_d;
    logic                   edge_w;

    assign edge_w = sync_q[SYNC_STAGES-1] & ~prev_q;
    assign cnt    = cnt_q;
    assign ovf    = ovf_q;

    // metastability chain for the asynchronous tap, plus one flop of history for edge detection
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], ring_in};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    // clear wins; an edge arriving while already saturated is lost and flags overflow
    always_comb begin
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (clear) begin
            cnt_d = '0;
            ovf_d = 1'b0;
        end else if (count_en && edge_w) begin
            if (&cnt_q) ovf_d = 1'b1;
            else        cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // live counter and overflow state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

endmodule

// File: rtl/instrumented_counter_bank.sv
// instrumented_counter_bank: windowed edge counting of NUM_CH ring oscillators with latched results
module instrumented_counter_bank
    import instrumented_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int CNT_W       = 32,
    parameter int TIME_W      = 32,
    parameter int SYNC_STAGES = 2,
    localparam int SEL_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [NUM_CH-1:0]       ring_in,
    input  logic [NUM_CH-1:0]       ch_enable,
    input  logic [TIME_W-1:0]       integration_time,
    input  logic                    start,
    input  logic                    abort,
    input  logic                    continuous,
    input  logic [SEL_W-1:0]        ch_sel,
    output logic [CNT_W-1:0]        count_out,
    output logic [NUM_CH-1:0]       overflow,
    output logic                    busy,
    output logic                    done,
    output logic [WINDOW_CNT_W-1:0] window_cnt
);

    state_e                         state_q, state_d;
    logic [TIME_W-1:0]              timer_q, timer_d;
    logic [NUM_CH-1:0]              en_q, en_d;
    logic [WINDOW_CNT_W-1:0]        wcnt_q, wcnt_d;
    logic                           busy_q;
    logic [NUM_CH-1:0][CNT_W-1:0]   live_w;
    logic [NUM_CH-1:0]              live_ovf_w;
    logic [NUM_CH-1:0][CNT_W-1:0]   res_q;
    logic [NUM_CH-1:0]              res_ovf_q;
    logic                           clear_w;
    logic                           commit_w;

    assign clear_w    = (state_q == ST_ARM);
    assign commit_w   = (state_q == ST_DONE) && !abort;
    assign done       = commit_w;
    assign busy       = busy_q;
    assign overflow   = res_ovf_q;
    assign window_cnt = wcnt_q;
    assign count_out  = (int'(ch_sel) < NUM_CH) ? res_q[ch_sel] : '0;

    genvar g;
    generate
        for (g = 0; g < NUM_CH; g++) begin : g_ch
            ring_edge_counter #(
                .CNT_W       (CNT_W),
                .SYNC_STAGES (SYNC_STAGES)
            ) u_cnt (
                .clk      (clk),
                .reset_n  (reset_n),
                .ring_in  (ring_in[g]),
                .clear    (clear_w),
                .count_en ((state_q == ST_COUNT) && en_q[g]),
                .cnt      (live_w[g]),
                .ovf      (live_ovf_w[g])
            );
        end
    endgenerate

    // next state, timer, enable snapshot and window count; abort overrides every transition
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        en_d    = en_q;
        wcnt_d  = wcnt_q;
        if (abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_d = ST_ARM;
                        wcnt_d  = '0;
                    end
                end
                ST_ARM: begin
                    timer_d = integration_time;
                    en_d    = ch_enable;
                    state_d = (integration_time == '0) ? ST_DONE : ST_COUNT;
                end
                ST_COUNT: begin
                    timer_d = timer_q - TIME_W'(1);
                    if (timer_q == TIME_W'(1)) state_d = ST_DONE;
                end
                ST_DONE: begin
                    wcnt_d  = wcnt_q + WINDOW_CNT_W'(1);
                    state_d = continuous ? ST_ARM : ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // control registers; busy is decoded from the next state so it is glitch-free and aligned with state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            timer_q <= '0;
            en_q    <= '0;
            wcnt_q  <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            en_q    <= en_d;
            wcnt_q  <= wcnt_d;
            busy_q  <= (state_d == ST_ARM) || (state_d == ST_COUNT);
        end
    end

    // result registers snapshot the live counters only on an unaborted window completion
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            res_q     <= '0;
            res_ovf_q <= '0;
        end else if (commit_w) begin
            res_q     <= live_w;
            res_ovf_q <= live_ovf_w;
        end
    end

endmodule

// File: tb/tb_instrumented_counter_bank.sv
// tb_instrumented_counter_bank: directed scoreboard bench for the ring-oscillator counter bank
module tb_instrumented_counter_bank;

    localparam int NUM_CH = 4;
    localparam int CNT_W  = 8;
    localparam int TIME_W = 16;

    logic                    clk = 1'b0;
    logic                    reset_n = 1'b0;
    logic                    start = 1'b0;
    logic                    abort = 1'b0;
    logic                    continuous = 1'b0;
    logic [NUM_CH-1:0]       ring_in = '0;
    logic [NUM_CH-1:0]       ch_enable = '0;
    logic [TIME_W-1:0]       integration_time = '0;
    logic [1:0]              ch_sel = '0;
    logic [CNT_W-1:0]        count_out;
    logic [NUM_CH-1:0]       overflow;
    logic                    busy;
    logic                    done;
    logic [15:0]             window_cnt;

    int half[NUM_CH] = '{5, 2, 3, 0};
    int ph[NUM_CH]   = '{0, 0, 0, 0};
    int n_chk  = 0;
    int n_fail = 0;

    typedef struct packed {
        logic [31:0]                  gap;
        logic [15:0]                  wc;
        logic [NUM_CH-1:0]            ovf;
        logic [NUM_CH-1:0][CNT_W-1:0] lo;
        logic [NUM_CH-1:0][CNT_W-1:0] hi;
    } exp_t;

    exp_t sbq[$];

    instrumented_counter_bank #(
        .NUM_CH      (NUM_CH),
        .CNT_W       (CNT_W),
        .TIME_W      (TIME_W),
        .SYNC_STAGES (2)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .ring_in          (ring_in),
        .ch_enable        (ch_enable),
        .integration_time (integration_time),
        .start            (start),
        .abort            (abort),
        .continuous       (continuous),
        .ch_sel           (ch_sel),
        .count_out        (count_out),
        .overflow         (overflow),
        .busy             (busy),
        .done             (done),
        .window_cnt       (window_cnt)
    );

    always #5 clk = ~clk;

    // free-running square waves: channel i toggles every half[i] clocks (period 2*half[i])
    always @(negedge clk) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (half[i] != 0) begin
                ph[i]++;
                if (ph[i] >= half[i]) begin
                    ph[i] = 0;
                    ring_in[i] = ~ring_in[i];
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic chk_rng(input string tag, input logic [31:0] got, input logic [31:0] lo, input logic [31:0] hi);
        n_chk++;
        assert (got >= lo && got <= hi) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d..%0d", tag, got, lo, hi);
        end
    endtask

    function automatic exp_t mk(input int gap, input int wc, input logic [NUM_CH-1:0] ovf,
                                input logic [NUM_CH-1:0][CNT_W-1:0] lo,
                                input logic [NUM_CH-1:0][CNT_W-1:0] hi);
        exp_t e;
        e.gap = 32'(gap);
        e.wc  = 16'(wc);
        e.ovf = ovf;
        e.lo  = lo;
        e.hi  = hi;
        return e;
    endfunction

    task automatic launch(input int t, input logic [NUM_CH-1:0] en, input logic cont);
        integration_time = TIME_W'(t);
        ch_enable        = en;
        continuous       = cont;
        start            = 1'b1;
    endtask

    task automatic wait_done(input int c0, output int cyc);
        cyc = c0;
        do begin
            tick();
            start = 1'b0;
            cyc++;
        end while (!done && cyc < 5000);
        if (!done) chk("done_timeout", {31'd0, done}, 32'd1);
    endtask

    task automatic check_regs(input exp_t e, input string tag);
        chk({tag, "_window_cnt"}, {16'd0, window_cnt}, {16'd0, e.wc});
        chk({tag, "_overflow"}, {28'd0, overflow}, {28'd0, e.ovf});
        for (int i = 0; i < NUM_CH; i++) begin
            ch_sel = 2'(i);
            #1;
            chk_rng($sformatf("%s_count_ch%0d", tag, i), {24'd0, count_out}, {24'd0, e.lo[i]}, {24'd0, e.hi[i]});
        end
    endtask

    task automatic check_window(input int cyc, input string tag);
        exp_t e;
        if (sbq.size() == 0) begin
            n_chk++;
            n_fail++;
            $error("FAIL %s_scoreboard: observed empty queue expected an entry", tag);
            return;
        end
        e = sbq.pop_front();
        chk({tag, "_gap"}, 32'(cyc), e.gap);
        tick();
        check_regs(e, tag);
    endtask

    initial begin
        int cyc;
        int seen;
        exp_t e;

        // reset state
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_window_cnt", {16'd0, window_cnt}, 32'd0);
        chk("rst_overflow", {28'd0, overflow}, 32'd0);
        chk("rst_count", {24'd0, count_out}, 32'd0);
        repeat (3) tick();
        reset_n = 1'b1;
        repeat (3) tick();

        // basic window: ch0 period 10 over 1000 cycles, other channels toggle but are disabled
        launch(1000, 4'b0001, 1'b0);
        sbq.push_back(mk(1002, 1, 4'b0000, {8'd0, 8'd0, 8'd0, 8'd99}, {8'd0, 8'd0, 8'd0, 8'd101}));
        wait_done(0, cyc);
        check_window(cyc, "basic");
        chk("basic_busy_after", {31'd0, busy}, 32'd0);

        // saturation: ch1 period 4 over 2000 cycles gives 500 edges into an 8-bit counter
        launch(2000, 4'b0010, 1'b0);
        sbq.push_back(mk(2002, 1, 4'b0010, {8'd0, 8'd0, 8'd255, 8'd0}, {8'd0, 8'd0, 8'd255, 8'd0}));
        wait_done(0, cyc);
        check_window(cyc, "sat");

        // zero-length window: straight from ARM to DONE, nothing counted
        launch(0, 4'b1111, 1'b0);
        sbq.push_back(mk(2, 1, 4'b0000, '0, '0));
        wait_done(0, cyc);
        check_window(cyc, "zero");

        // continuous mode: five back-to-back windows of 100 cycles
        launch(100, 4'b0001, 1'b1);
        for (int w = 1; w <= 5; w++)
            sbq.push_back(mk(102, w, 4'b0000, {8'd0, 8'd0, 8'd0, 8'd9}, {8'd0, 8'd0, 8'd0, 8'd11}));
        for (int w = 0; w < 5; w++) begin
            wait_done((w == 0) ? 0 : 1, cyc);
            check_window(cyc, $sformatf("cont%0d", w + 1));
            if (w == 3) continuous = 1'b0;
        end
        seen = 0;
        repeat (10) begin
            tick();
            seen |= int'(busy | done);
        end
        chk("cont_stops_idle", 32'(seen), 32'd0);

        // abort 50 cycles into a 1000-cycle window: no done, prior results kept, window_cnt cleared by start
        launch(1000, 4'b0001, 1'b0);
        sbq.push_back(mk(0, 0, 4'b0000, {8'd0, 8'd0, 8'd0, 8'd9}, {8'd0, 8'd0, 8'd0, 8'd11}));
        tick();
        start = 1'b0;
        seen = 0;
        repeat (50) begin
            tick();
            seen |= int'(done);
        end
        chk("abort_busy_before", {31'd0, busy}, 32'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        repeat (20) begin
            tick();
            seen |= int'(done | busy);
        end
        chk("abort_no_done", 32'(seen), 32'd0);
        e = sbq.pop_front();
        check_regs(e, "abort");

        // asynchronous reset in the middle of COUNT
        launch(1000, 4'b0001, 1'b0);
        tick();
        start = 1'b0;
        repeat (30) tick();
        chk("mid_busy", {31'd0, busy}, 32'd1);
        ch_sel = 2'd0;
        reset_n = 1'b0;
        #2;
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_done", {31'd0, done}, 32'd0);
        chk("arst_window_cnt", {16'd0, window_cnt}, 32'd0);
        chk("arst_overflow", {28'd0, overflow}, 32'd0);
        chk("arst_count", {24'd0, count_out}, 32'd0);
        #10;
        reset_n = 1'b1;
        seen = 0;
        repeat (5) begin
            tick();
            seen |= int'(busy | done);
        end
        chk("arst_stays_idle", 32'(seen), 32'd0);
        launch(100, 4'b0001, 1'b0);
        sbq.push_back(mk(102, 1, 4'b0000, {8'd0, 8'd0, 8'd0, 8'd9}, {8'd0, 8'd0, 8'd0, 8'd11}));
        wait_done(0, cyc);
        check_window(cyc, "post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
